data_mem_responder: RTL
=======================

Name: data_mem_responder

Overview:
Multi-lane data-memory responder: the slave end of the per-lane LSU data-memory handshake driven by the SIMD unit. It accepts up to LANE_WIDTH concurrent read/write requests and arbitrates them round-robin onto NUM_CHANNELS memory access slots per cycle. It services them against an internal word-addressed array and returns per-lane read data and acks. A host preload port initialises and inspects memory before kernel launch.

Parameters:
DATA_WIDTH, 64, word width
ADDR_WIDTH, 7, word address width; array depth 2^ADDR_WIDTH
LANE_WIDTH, 16, number of requesting lanes
NUM_CHANNELS, 4, max lane accesses serviced per cycle (1..LANE_WIDTH)

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  asynchronous, active-low reset
mem_read_valid  input  LANE_WIDTH  per-lane read request
mem_write_valid  input  LANE_WIDTH  per-lane write request
mem_addr  input  ADDR_WIDTH x LANE_WIDTH  per-lane word address
mem_write_data  input  DATA_WIDTH x LANE_WIDTH  per-lane write data
data_mem_ready_ack  output  LANE_WIDTH  per-lane read complete
data_mem_write_ack  output  LANE_WIDTH  per-lane write complete
mem_read_data  output  DATA_WIDTH x LANE_WIDTH  per-lane read result, valid while read ack high
host_we  input  1  host write strobe
host_addr  input  ADDR_WIDTH  host address
host_wdata  input  DATA_WIDTH  host write data
host_rdata  output  DATA_WIDTH  combinational array[host_addr]

Behaviour:
- Reset (rst=0, async): all acks 0, all mem_read_data 0, lane states IDLE, rr_ptr 0. Array contents not cleared.
- Per-lane FSM: IDLE, WAIT, DONE. A lane is a request when rd|wr valid is high. If both are high, it is treated as a write; the read is ignored.
- Eligible in cycle c: (IDLE and request) or (WAIT and request).
- Arbitration: scan lanes from rr_ptr upward, modulo LANE_WIDTH. Grant the first NUM_CHANNELS eligible lanes.
- rr_ptr update: rr_ptr <= (last granted lane + 1) mod LANE_WIDTH. If nothing is granted, rr_ptr is unchanged.
- Granted lane, at the edge ending cycle c:
  - Write: array[addr] <= wdata; data_mem_write_ack <= 1.
  - Read: mem_read_data <= array[addr] (pre-write value for the same cycle); data_mem_ready_ack <= 1.
  - Lane goes to DONE.
- Latency: a granted lane's ack is visible in cycle c+1.
- Eligible lane not granted goes to WAIT. Address and data are sampled only in the grant cycle; the requester holds them stable until ack.
- WAIT with request withdrawn goes to IDLE. No access is performed and no ack is issued.
- DONE: ack and read data held while the originating valid stays high. When valid is seen low, the lane goes to IDLE and ack clears at that edge, so ack falls one cycle after valid falls. mem_read_data retains its value.
- A new request is accepted only from IDLE, so at least one valid-low cycle separates transactions.
- Same-address writes in one cycle: the lane granted later in scan order wins.
- host_we=1: the host write is performed and no lane is granted that cycle; all eligible lanes go to or stay in WAIT.
- Reset asserted mid-operation: all pending and DONE lanes are dropped immediately and acks clear asynchronously. Partially granted writes from the reset edge are not performed.

Test Plan:
- host_we preloads array[5]=0xAA. Lane 3 asserts read addr 5 in cycle 0. Expect data_mem_ready_ack[3]=1 and mem_read_data[3]=0xAA in cycle 1, held. Deassert valid in cycle 2; expect ack=0 in cycle 3.
- All 16 lanes read addr=lane in cycle 0, valids held until ack, NUM_CHANNELS=4. Expect acks for lanes 0-3 in cycle 1, 4-7 in cycle 2, 8-11 in cycle 3, 12-15 in cycle 4. rr_ptr ends at 0.
- Lanes 2 and 9 write addr 7 with 0x11 and 0x22 in the same cycle, rr_ptr=0. Both write acks fire. A subsequent read of addr 7 returns 0x22.
- Lane 0 writes 0x55 to addr 1 while lane 1 reads addr 1 in the same grant cycle, old value 0x0. Lane 1 gets 0x0; a later read returns 0x55.
- Lanes 0-15 request with NUM_CHANNELS=4; lane 12 drops valid while in WAIT. Lane 12 gets no ack and array[lane 12's addr] is unchanged. Others complete in order.
- host_we=1 in the cycle lane 0 requests: no ack in the next cycle, ack one cycle later. Separately, assert rst=0 while 8 lanes wait: all acks 0 immediately, and all states IDLE after release.

Source files
------------

// File: rtl/data_mem_responder.sv
// data_mem_responder: multi-lane data-memory slave with round-robin channel arbitration
// and a host preload/inspect port onto a word-addressed array.
module data_mem_responder #(
  parameter int DATA_WIDTH   = 64,
  parameter int ADDR_WIDTH   = 7,
  parameter int LANE_WIDTH   = 16,
  parameter int NUM_CHANNELS = 4
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [LANE_WIDTH-1:0]                mem_read_valid,
  input  logic [LANE_WIDTH-1:0]                mem_write_valid,
  input  logic [LANE_WIDTH-1:0][ADDR_WIDTH-1:0] mem_addr,
  input  logic [LANE_WIDTH-1:0][DATA_WIDTH-1:0] mem_write_data,
  output logic [LANE_WIDTH-1:0]                data_mem_ready_ack,
  output logic [LANE_WIDTH-1:0]                data_mem_write_ack,
  output logic [LANE_WIDTH-1:0][DATA_WIDTH-1:0] mem_read_data,
  input  logic                                 host_we,
  input  logic [ADDR_WIDTH-1:0]                host_addr,
  input  logic [DATA_WIDTH-1:0]                host_wdata,
  output logic [DATA_WIDTH-1:0]                host_rdata
);
  localparam int IW = LANE_WIDTH > 1 ? $clog2(LANE_WIDTH) : 1;
  typedef enum logic [1:0] {IDLE, WAIT, DONE} lane_state_t;
  lane_state_t state [LANE_WIDTH];
  lane_state_t state_next [LANE_WIDTH];
  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
  logic [LANE_WIDTH-1:0] req, grant, op_wr, orig_valid;
  logic [IW-1:0] rr_ptr, rr_next;
  logic [IW-1:0] scan [LANE_WIDTH];
  assign req = mem_read_valid | mem_write_valid;
  assign orig_valid = (op_wr & mem_write_valid) | (~op_wr & mem_read_valid);
  assign host_rdata = mem[host_addr];
  // scan[k] is the k-th lane in round-robin order starting at rr_ptr
  for (genvar k = 0; k < LANE_WIDTH; k++) begin : g_scan
    assign scan[k] = IW'((int'(rr_ptr) + k) % LANE_WIDTH);
  end
  always_comb begin : arb
    int cnt;
    cnt = 0;
    grant = '0;
    rr_next = rr_ptr;
    for (int k = 0; k < LANE_WIDTH; k++)
      if (rst && !host_we && req[scan[k]] && state[scan[k]] != DONE && cnt < NUM_CHANNELS) begin
        grant[scan[k]] = 1'b1;
        cnt = cnt + 1;
        rr_next = IW'((int'(scan[k]) + 1) % LANE_WIDTH);
      end
  end
  always_comb
    for (int i = 0; i < LANE_WIDTH; i++)
      state_next[i] = grant[i] ? DONE :
                      state[i] == DONE ? (orig_valid[i] ? DONE : IDLE) :
                      req[i] ? WAIT : IDLE;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      for (int i = 0; i < LANE_WIDTH; i++) state[i] <= IDLE;
      rr_ptr <= '0;
    end else begin
      for (int i = 0; i < LANE_WIDTH; i++) state[i] <= state_next[i];
      rr_ptr <= rr_next;
    end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      data_mem_ready_ack <= '0;
      data_mem_write_ack <= '0;
      mem_read_data <= '0;
      op_wr <= '0;
    end else begin
      for (int i = 0; i < LANE_WIDTH; i++)
        if (grant[i]) begin
          op_wr[i] <= mem_write_valid[i];
          data_mem_write_ack[i] <= mem_write_valid[i];
          data_mem_ready_ack[i] <= ~mem_write_valid[i];
          if (!mem_write_valid[i]) mem_read_data[i] <= mem[mem_addr[i]];
        end else if (state_next[i] != DONE) begin
          data_mem_write_ack[i] <= 1'b0;
          data_mem_ready_ack[i] <= 1'b0;
        end
    end
  // writes issue in scan order so the later-granted lane wins an address collision
  always_ff @(posedge clk)
    if (host_we) mem[host_addr] <= host_wdata;
    else
      for (int k = 0; k < LANE_WIDTH; k++)
        if (grant[scan[k]] && mem_write_valid[scan[k]])
          mem[mem_addr[scan[k]]] <= mem_write_data[scan[k]];
endmodule
